param_updown_counter: RTL and testbench

- Parametrised modulo-N up/down counter; next generation of the mod-12 up/down counter. Same load/mode/data_in/data_out contract, generalised in width and modulus.
- Adds: count enable, runtime saturate-vs-wrap mode, registered carry/borrow pulses, load range checking and a wrap event counter.
- Used standalone or cascaded: carry_out/borrow_out of one stage drives enable of the next.

---
 rtl/param_updown_counter_if.sv | 29 ++
 rtl/param_updown_counter.sv | 96 +++++++++
 tb/tb_param_updown_counter.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/param_updown_counter_if.sv
// Control/data bundle for param_updown_counter: the master drives count controls
// and load data, the slave (counter) returns the count, pulses and wrap total.
interface param_updown_counter_if #(
  parameter int WIDTH  = 4,
  parameter int WRAP_W = 8
);
  logic              enable;
  logic              load;
  logic              mode;
  logic              sat_mode;
  logic [WIDTH-1:0]  data_in;
  logic [WIDTH-1:0]  data_out;
  logic              carry_out;
  logic              borrow_out;
  logic              at_max;
  logic              at_min;
  logic              load_err;
  logic [WRAP_W-1:0] wrap_count;

  modport master (
    output enable, load, mode, sat_mode, data_in,
    input  data_out, carry_out, borrow_out, at_max, at_min, load_err, wrap_count
  );

  modport slave (
    input  enable, load, mode, sat_mode, data_in,
    output data_out, carry_out, borrow_out, at_max, at_min, load_err, wrap_count
  );
endinterface

// File: rtl/param_updown_counter.sv
// Modulo-MODULUS up/down counter with enable, saturate/wrap mode, registered
// carry/borrow pulses, load range checking and a saturating wrap event counter.
module param_updown_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 12,
  parameter int WRAP_W  = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  param_updown_counter_if.slave bus
);

  if (MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_modulus
    $error("param_updown_counter: MODULUS %0d outside 2..2**WIDTH", MODULUS);
  end

  // Range constants at WIDTH+1 bits so MODULUS == 2**WIDTH is representable.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0]   MAX_EXT = MOD_EXT - (WIDTH+1)'(1);
  localparam logic [WIDTH-1:0] MAX_VAL = MAX_EXT[WIDTH-1:0];

  logic [WIDTH-1:0]  r_count;
  logic              r_carry;
  logic              r_borrow;
  logic              r_load_err;
  logic [WRAP_W-1:0] r_wrap;

  logic [WIDTH:0]    w_cnt_ext;
  logic [WIDTH:0]    w_inc;
  logic [WIDTH-1:0]  w_next;
  logic              w_carry;
  logic              w_borrow;
  logic              w_load_err;

  assign w_cnt_ext = {1'b0, r_count};
  assign w_inc     = w_cnt_ext + (WIDTH+1)'(1);

  // Load wins over counting regardless of enable; pulses only come from counting.
  always_comb begin
    w_next     = r_count;
    w_carry    = 1'b0;
    w_borrow   = 1'b0;
    w_load_err = 1'b0;
    if (bus.load) begin
      if ({1'b0, bus.data_in} < MOD_EXT) begin
        w_next = bus.data_in;
      end else begin
        w_next     = MAX_VAL;
        w_load_err = 1'b1;
      end
    end else if (bus.enable) begin
      if (bus.mode) begin
        if (w_cnt_ext < MAX_EXT) begin
          w_next = w_inc[WIDTH-1:0];
        end else if (!bus.sat_mode) begin
          w_next  = '0;
          w_carry = 1'b1;
        end
      end else begin
        if (r_count != '0) begin
          w_next = r_count - WIDTH'(1);
        end else if (!bus.sat_mode) begin
          w_next   = MAX_VAL;
          w_borrow = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count    <= '0;
      r_carry    <= 1'b0;
      r_borrow   <= 1'b0;
      r_load_err <= 1'b0;
      r_wrap     <= '0;
    end else begin
      r_count    <= w_next;
      r_carry    <= w_carry;
      r_borrow   <= w_borrow;
      r_load_err <= w_load_err;
      if ((w_carry || w_borrow) && (r_wrap != '1)) begin
        r_wrap <= r_wrap + WRAP_W'(1);
      end
    end
  end

  assign bus.data_out   = r_count;
  assign bus.carry_out  = r_carry;
  assign bus.borrow_out = r_borrow;
  assign bus.load_err   = r_load_err;
  assign bus.wrap_count = r_wrap;
  assign bus.at_max     = (r_count == MAX_VAL);
  assign bus.at_min     = (r_count == '0);

endmodule

// File: tb/tb_param_updown_counter.sv
// Bench for param_updown_counter: a mod-12 and a mod-8 instance checked every
// cycle against an integer model, plus literal expectations along the way.
module tb_param_updown_counter;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  bit   chk_en = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  param_updown_counter_if #(.WIDTH(4), .WRAP_W(8)) if_a ();
  param_updown_counter_if #(.WIDTH(3), .WRAP_W(2)) if_b ();

  param_updown_counter #(.WIDTH(4), .MODULUS(12), .WRAP_W(8)) u_a (
    .clock(clk), .reset(rst_n), .bus(if_a)
  );
  param_updown_counter #(.WIDTH(3), .MODULUS(8), .WRAP_W(2)) u_b (
    .clock(clk), .reset(rst_n), .bus(if_b)
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: the count is an integer in [0, M); stepping past either end either
  // wraps around (a wrap event) or stays put when saturating.
  function automatic void mstep(input int m, input int wmax, input bit ld, input bit en,
                                input bit up, input bit sat, input int din,
                                inout int cnt, output bit c, output bit b,
                                output bit le, inout int wr);
    int target;
    c = 0; b = 0; le = 0;
    if (ld) begin
      le  = (din >= m);
      cnt = le ? m - 1 : din;
    end else if (en) begin
      target = up ? cnt + 1 : cnt - 1;
      if (target >= 0 && target < m) cnt = target;
      else if (!sat) begin
        cnt = (target + m) % m;
        c = up;
        b = !up;
      end
    end
    if ((c || b) && wr < wmax) wr++;
  endfunction

  int ma_cnt, ma_wr, mb_cnt, mb_wr;
  bit ma_c, ma_b, ma_le, mb_c, mb_b, mb_le;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma_cnt = 0; ma_wr = 0; ma_c = 0; ma_b = 0; ma_le = 0;
      mb_cnt = 0; mb_wr = 0; mb_c = 0; mb_b = 0; mb_le = 0;
    end else begin
      mstep(12, 255, if_a.load, if_a.enable, if_a.mode, if_a.sat_mode, int'(if_a.data_in),
            ma_cnt, ma_c, ma_b, ma_le, ma_wr);
      mstep(8, 3, if_b.load, if_b.enable, if_b.mode, if_b.sat_mode, int'(if_b.data_in),
            mb_cnt, mb_c, mb_b, mb_le, mb_wr);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("A_data",   if_a.data_out,   ma_cnt);
      check("A_carry",  if_a.carry_out,  ma_c);
      check("A_borrow", if_a.borrow_out, ma_b);
      check("A_lerr",   if_a.load_err,   ma_le);
      check("A_wrap",   if_a.wrap_count, ma_wr);
      check("A_atmax",  if_a.at_max,     ma_cnt == 11);
      check("A_atmin",  if_a.at_min,     ma_cnt == 0);
      check("B_data",   if_b.data_out,   mb_cnt);
      check("B_carry",  if_b.carry_out,  mb_c);
      check("B_borrow", if_b.borrow_out, mb_b);
      check("B_wrap",   if_b.wrap_count, mb_wr);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_a(input bit ld, input bit en, input bit up, input bit sat,
                         input logic [3:0] din);
    if_a.load = ld; if_a.enable = en; if_a.mode = up; if_a.sat_mode = sat; if_a.data_in = din;
  endtask

  initial begin
    drive_a(0, 0, 0, 0, 4'd0);
    if_b.load = 0; if_b.enable = 0; if_b.mode = 1; if_b.sat_mode = 0; if_b.data_in = '0;

    repeat (2) cyc();
    check("rst_data",  if_a.data_out, 0);
    check("rst_atmin", if_a.at_min, 1);
    check("rst_atmax", if_a.at_max, 0);
    check("rst_wrap",  if_a.wrap_count, 0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    drive_a(1, 0, 1, 0, 4'd7); cyc();
    check("load7", if_a.data_out, 7);
    check("load7_err", if_a.load_err, 0);

    drive_a(0, 1, 1, 0, 4'd0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("up_seq", if_a.data_out, 8 + i);
    end
    check("up_atmax", if_a.at_max, 1);

    cyc();
    check("wrap_up_data", if_a.data_out, 0);
    check("wrap_up_carry", if_a.carry_out, 1);
    check("wrap_up_cnt", if_a.wrap_count, 1);

    drive_a(0, 1, 0, 0, 4'd0); cyc();
    check("wrap_dn_data", if_a.data_out, 11);
    check("wrap_dn_borrow", if_a.borrow_out, 1);
    check("wrap_dn_carry", if_a.carry_out, 0);
    check("wrap_dn_cnt", if_a.wrap_count, 2);

    drive_a(0, 1, 1, 1, 4'd0);
    repeat (3) cyc();
    check("sat_up_data", if_a.data_out, 11);
    check("sat_up_carry", if_a.carry_out, 0);

    drive_a(1, 0, 0, 1, 4'd0); cyc();
    drive_a(0, 1, 0, 1, 4'd0);
    repeat (2) cyc();
    check("sat_dn_data", if_a.data_out, 0);
    check("sat_dn_borrow", if_a.borrow_out, 0);
    check("sat_wrap_cnt", if_a.wrap_count, 2);

    drive_a(1, 0, 0, 0, 4'd14); cyc();
    check("load14_data", if_a.data_out, 11);
    check("load14_err", if_a.load_err, 1);
    drive_a(1, 1, 1, 0, 4'd3); cyc();
    check("load3_en_data", if_a.data_out, 3);
    check("load3_en_err", if_a.load_err, 0);
    drive_a(1, 0, 0, 0, 4'd12); cyc();
    check("load12_data", if_a.data_out, 11);
    check("load12_err", if_a.load_err, 1);
    drive_a(1, 0, 0, 0, 4'd11); cyc();
    check("load11_err", if_a.load_err, 0);

    drive_a(1, 0, 0, 0, 4'd5); cyc();
    drive_a(0, 0, 1, 0, 4'd0);
    repeat (5) cyc();
    check("hold_data", if_a.data_out, 5);

    drive_a(0, 1, 1, 0, 4'd0); cyc();
    check("pre_rst_data", if_a.data_out, 6);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_data", if_a.data_out, 0);
    check("async_rst_wrap", if_a.wrap_count, 0);
    cyc();
    rst_n = 1'b1;
    drive_a(0, 0, 1, 0, 4'd0);

    if_b.enable = 1; if_b.mode = 1; if_b.sat_mode = 0;
    for (int i = 1; i <= 40; i++) begin
      cyc();
      if (i == 7)  check("B_at7", if_b.data_out, 7);
      if (i == 8) begin
        check("B_wrap8_data", if_b.data_out, 0);
        check("B_wrap8_carry", if_b.carry_out, 1);
      end
      if (i == 9)  check("B_carry_drop", if_b.carry_out, 0);
      if (i == 16) check("B_wcnt16", if_b.wrap_count, 2);
      if (i == 24) check("B_wcnt24", if_b.wrap_count, 3);
    end
    check("B_final_data", if_b.data_out, 0);
    check("B_final_wcnt", if_b.wrap_count, 3);

    @(negedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
